// File: rtl/run_pkg.sv
// Shared types and constants for the program run controller.
// Holds the FSM state encoding, program select codes, result byte addresses
// and the mapping from a program select to its result read-back plan.
package run_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StRdHi,
        StRdLo,
        StCap,
        StDone
    } run_state_e;

    localparam logic [1:0] PROG_MUL     = 2'd0;
    localparam logic [1:0] PROG_SRCH    = 2'd1;
    localparam logic [1:0] PROG_DIST    = 2'd2;
    localparam logic [1:0] PROG_ILLEGAL = 2'd3;

    localparam logic [7:0] MUL_HI_ADDR = 8'd4;
    localparam logic [7:0] MUL_LO_ADDR = 8'd5;
    localparam logic [7:0] SRCH_ADDR   = 8'd7;
    localparam logic [7:0] DIST_ADDR   = 8'd127;

    // Result reported when the watchdog aborts a run
    localparam logic [15:0] WDOG_RESULT = 16'hDEAD;

    typedef struct packed {
        logic [7:0] hi_addr;
        logic [7:0] lo_addr;
        logic       two_byte;
    } rd_map_t;

    function automatic logic prog_legal(input logic [1:0] sel);
        return sel != PROG_ILLEGAL;
    endfunction

    // Single-byte programs read their only byte through the hi slot
    function automatic rd_map_t prog_rd_map(input logic [1:0] sel);
        rd_map_t m;
        m = '{hi_addr: MUL_HI_ADDR, lo_addr: MUL_LO_ADDR, two_byte: 1'b1};
        case (sel)
            PROG_SRCH: m = '{hi_addr: SRCH_ADDR, lo_addr: 8'd0, two_byte: 1'b0};
            PROG_DIST: m = '{hi_addr: DIST_ADDR, lo_addr: 8'd0, two_byte: 1'b0};
            default:   m = '{hi_addr: MUL_HI_ADDR, lo_addr: MUL_LO_ADDR, two_byte: 1'b1};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/run_cycle_ctr.sv
// Saturating cycle counter with synchronous clear and count enable.
// Clear has priority over enable; the count sticks at all-ones.
module run_cycle_ctr #(
    parameter int unsigned W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, holding at the maximum value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/prog_run_ctrl.sv
// Run controller: loads the core PC for the selected program, runs the core
// until halt, reads the result bytes back from data memory and reports a
// packed result with the run's cycle count.
// Optional watchdog abort is built when RUN_WATCHDOG_EN is defined.
module prog_run_ctrl
    import run_pkg::*;
#(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned CYC_W      = 24,
    parameter int unsigned PROG0_PC   = 0,
    parameter int unsigned PROG1_PC   = 128,
    parameter int unsigned PROG2_PC   = 256,
    parameter int unsigned WDOG_LIMIT = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        prog_sel,
    input  logic              halt,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_init,
    output logic              core_en,
    output logic              dm_rd_en,
    output logic [ADDR_W-1:0] dm_addr,
    input  logic [7:0]        dm_rdata,
    output logic [15:0]       result,
    output logic [CYC_W-1:0]  cycles,
    output logic              done,
    output logic              err
);

`ifdef RUN_WATCHDOG_EN
    localparam bit WdogEn = 1'b1;
`else
    localparam bit WdogEn = 1'b0;
`endif

    run_state_e state_q;
    logic [1:0] sel_q;
    rd_map_t    rd_map;
    logic       start_ok;
    logic       wdog_trip;

    function automatic logic [PC_W-1:0] entry_pc(input logic [1:0] sel);
        case (sel)
            PROG_MUL:  return PC_W'(PROG0_PC);
            PROG_SRCH: return PC_W'(PROG1_PC);
            PROG_DIST: return PC_W'(PROG2_PC);
            default:   return '0;
        endcase
    endfunction

    assign rd_map   = prog_rd_map(sel_q);
    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    // Fires on the RUN cycle whose increment brings the count to the limit
    assign wdog_trip = WdogEn && (cycles == CYC_W'(WDOG_LIMIT - 1));

    run_cycle_ctr #(
        .W (CYC_W)
    ) u_cycle_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .en    (state_q == StRun),
        .count (cycles)
    );

    // Run sequencing with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            pc_load  <= 1'b0;
            pc_init  <= '0;
            core_en  <= 1'b0;
            dm_rd_en <= 1'b0;
            dm_addr  <= '0;
            result   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            pc_load  <= 1'b0;
            dm_rd_en <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_ok) begin
                        state_q <= StLoad;
                        sel_q   <= prog_sel;
                        pc_load <= prog_legal(prog_sel);
                        pc_init <= entry_pc(prog_sel);
                        result  <= '0;
                        done    <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                StLoad: begin
                    // An illegal select never enables the core
                    if (!prog_legal(sel_q)) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        state_q <= StRun;
                        core_en <= 1'b1;
                    end
                end
                StRun: begin
                    if (halt) begin
                        state_q  <= StRdHi;
                        core_en  <= 1'b0;
                        dm_rd_en <= 1'b1;
                        dm_addr  <= ADDR_W'(rd_map.hi_addr);
                    end else if (wdog_trip) begin
                        state_q <= StDone;
                        core_en <= 1'b0;
                        result  <= WDOG_RESULT;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end
                end
                StRdHi: begin
                    state_q <= StRdLo;
                    if (rd_map.two_byte) begin
                        dm_rd_en <= 1'b1;
                        dm_addr  <= ADDR_W'(rd_map.lo_addr);
                    end
                end
                StRdLo: begin
                    // First read data is valid now
                    state_q <= StCap;
                    if (rd_map.two_byte) begin
                        result[15:8] <= dm_rdata;
                    end else begin
                        result[7:0] <= dm_rdata;
                    end
                end
                StCap: begin
                    state_q <= StDone;
                    done    <= 1'b1;
                    if (rd_map.two_byte) begin
                        result[7:0] <= dm_rdata;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
